div_sched: RTL

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_sched_pkg.sv | 12 +
 rtl/div_sched_if.sv | 36 +++
 rtl/div_sched_arb.sv | 32 +++
 rtl/div_sched.sv | 84 ++++++++
 4 files changed

// File: rtl/div_sched_pkg.sv
// div_sched_pkg: operation and FSM state types shared by the divider scheduler.
package rv32i_types;
  typedef enum logic [1:0] {OP_DIV, OP_DIVU, OP_REM, OP_REMU} div_op_t;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} div_state_t;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  function automatic logic op_signed(div_op_t op);
    return op == OP_DIV || op == OP_REM;
  endfunction
  function automatic logic op_rem(div_op_t op);
    return op == OP_REM || op == OP_REMU;
  endfunction
endpackage

// File: rtl/div_sched_if.sv
// div_sched_if: requester, divider and result-bus signals of the divider scheduler.
interface div_sched_if #(
  parameter int NUM_REQ   = 2,
  parameter int TAG_WIDTH = 5
);
  logic                              flush;
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ-1:0][1:0]           req_op;
  logic [NUM_REQ-1:0][31:0]          req_a;
  logic [NUM_REQ-1:0][31:0]          req_b;
  logic [NUM_REQ-1:0][TAG_WIDTH-1:0] req_tag;
  logic                              div_start;
  logic [31:0]                       div_a;
  logic [31:0]                       div_b;
  logic                              div_signed;
  logic                              div_complete;
  logic [31:0]                       div_quotient;
  logic [31:0]                       div_remainder;
  logic                              out_valid;
  logic                              out_ready;
  logic [TAG_WIDTH-1:0]              out_tag;
  logic [31:0]                       out_result;
  modport master (
    output flush, req_valid, req_op, req_a, req_b, req_tag,
           div_complete, div_quotient, div_remainder, out_ready,
    input  req_ready, div_start, div_a, div_b, div_signed,
           out_valid, out_tag, out_result
  );
  modport slave (
    input  flush, req_valid, req_op, req_a, req_b, req_tag,
           div_complete, div_quotient, div_remainder, out_ready,
    output req_ready, div_start, div_a, div_b, div_signed,
           out_valid, out_tag, out_result
  );
endinterface

// File: rtl/div_sched_arb.sv
// rr_arbiter: round-robin arbiter; the requester after the last-granted one wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [IW-1:0] r_last, w_idx, w_cand;
  logic          w_found;
  // scan downward so the nearest candidate after r_last is written last
  always_comb begin
    w_idx   = r_last;
    w_cand  = r_last;
    w_found = 1'b0;
    o_grant = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_cand = IW'((int'(r_last) + i) % NUM_REQ);
      if (i_valid[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
    o_grant[w_idx] = w_found;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_last <= IW'(NUM_REQ - 1);
    else if (i_advance) r_last <= w_idx;
endmodule

// File: rtl/div_sched.sv
// div_sched: shares one sequential divider among NUM_REQ requesters, one op in flight,
// with a fast path for divide-by-zero and signed overflow.
module div_sched
  import rv32i_types::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int TAG_WIDTH = 5
) (
  input logic        clk,
  input logic        rst_n,
  div_sched_if.slave bus
);
  div_state_t           r_state, w_next;
  div_op_t              r_op, w_op;
  logic [31:0]          r_a, r_b, r_result, w_a, w_b, w_fast_res;
  logic [TAG_WIDTH-1:0] r_tag, w_tag;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_open, w_accept, w_fast;

  assign w_open        = rst_n && r_state == S_IDLE && !bus.flush;
  assign bus.req_ready = w_grant & {NUM_REQ{w_open}};
  assign w_accept      = |bus.req_ready;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (bus.req_valid),
    .i_advance (w_accept),
    .o_grant   (w_grant)
  );

  always_comb begin
    w_op  = OP_DIV;
    w_a   = '0;
    w_b   = '0;
    w_tag = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (w_grant[i]) begin
        w_op  = div_op_t'(bus.req_op[i]);
        w_a   = bus.req_a[i];
        w_b   = bus.req_b[i];
        w_tag = bus.req_tag[i];
      end
  end

  // these two cases are answered without the divider
  assign w_fast     = w_b == '0 || (op_signed(w_op) && w_a == INT_MIN && w_b == '1);
  assign w_fast_res = w_b == '0 ? (op_rem(w_op) ? w_a : '1) : (op_rem(w_op) ? '0 : INT_MIN);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_accept ? (w_fast ? S_RESP : S_ISSUE) : S_IDLE;
      S_ISSUE: w_next = bus.flush ? S_DRAIN : S_WAIT;
      S_WAIT:  w_next = bus.flush ? S_DRAIN : (bus.div_complete ? S_RESP : S_WAIT);
      S_RESP:  w_next = (bus.flush || bus.out_ready) ? S_IDLE : S_RESP;
      S_DRAIN: w_next = bus.div_complete ? S_IDLE : S_DRAIN;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;

  always_ff @(posedge clk)
    if (w_accept) begin
      r_op     <= w_op;
      r_a      <= w_a;
      r_b      <= w_b;
      r_tag    <= w_tag;
      r_result <= w_fast_res;
    end else if (r_state == S_WAIT && bus.div_complete) begin
      r_result <= op_rem(r_op) ? bus.div_remainder : bus.div_quotient;
    end

  assign bus.div_start  = r_state == S_ISSUE;
  assign bus.div_a      = r_a;
  assign bus.div_b      = r_b;
  assign bus.div_signed = op_signed(r_op);
  assign bus.out_valid  = r_state == S_RESP;
  assign bus.out_tag    = r_tag;
  assign bus.out_result = r_result;
endmodule
